// File: rtl/sakebi_frame_writer.sv
// -----------------------------------------------------------------------------
// sakebi_frame_writer
//
// Collects an upstream byte stream into a local frame buffer, then writes the
// frame into an asynchronous FIFO write port as:
//   header  : payload length L (1..MAX_LEN)
//   payload : the L collected words, in arrival order
//   trailer : XOR of the L payload words (only with SAKEBI_FRAME_WRITER_CHECKSUM_EN)
// A frame closes on i_s_last, or is force-split once MAX_LEN beats have been
// collected (o_overflow pulses on that beat). The remaining beats of the
// stream then start a new frame.
//
// Optional feature macro: SAKEBI_FRAME_WRITER_CHECKSUM_EN (trailer word).
//
// Parameters
//   DATA_WIDTH : width of stream beats and FIFO words
//   MAX_LEN    : maximum payload beats per frame (2 .. 2**DATA_WIDTH-1)
//
// Ports
//   i_wr_clk     : write-domain clock, rising edge
//   i_wr_rstn    : asynchronous active-low reset
//   i_s_valid    : upstream beat valid
//   i_s_data     : upstream beat data
//   i_s_last     : final beat of a frame
//   o_s_ready    : a beat can be accepted this cycle (only while collecting)
//   o_wr_en      : FIFO write strobe (combinational with i_wr_ready)
//   o_wr_data    : FIFO write word, held stable while stalled
//   i_wr_ready   : FIFO not full
//   o_frame_done : pulse on the final FIFO write of a frame
//   o_overflow   : pulse on the beat that force-splits a frame at MAX_LEN
// -----------------------------------------------------------------------------
module sakebi_frame_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16
) (
  input  logic                  i_wr_clk,
  input  logic                  i_wr_rstn,
  input  logic                  i_s_valid,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_last,
  output logic                  o_s_ready,
  output logic                  o_wr_en,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic                  i_wr_ready,
  output logic                  o_frame_done,
  output logic                  o_overflow
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_LEN - 1);

`ifdef SAKEBI_FRAME_WRITER_CHECKSUM_EN
  typedef enum logic [1:0] {COLLECT, HEADER, PAYLOAD, TRAILER} state_t;
`else
  typedef enum logic [1:0] {COLLECT, HEADER, PAYLOAD} state_t;
`endif

  state_t state, state_nxt;

  // cnt doubles as the stored length L once the frame is closed.
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         idx;
  logic [DATA_WIDTH-1:0] wr_data_p0;
  logic [DATA_WIDTH-1:0] buffer [0:MAX_LEN-1];
`ifdef SAKEBI_FRAME_WRITER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_p0;
`endif

  logic accept_beat;
  logic close_beat;
  logic pay_last;

  // Zero-extend a beat count into a FIFO word (CW never exceeds DATA_WIDTH).
  function automatic logic [DATA_WIDTH-1:0] len_word(input logic [CW-1:0] n);
    return DATA_WIDTH'(n);
  endfunction

  assign accept_beat = (state == COLLECT) && i_s_valid;
  assign close_beat  = accept_beat && (i_s_last || (cnt == LAST_SLOT));
  assign pay_last    = (idx == (cnt - CW'(1)));
  assign o_wr_data   = wr_data_p0;

  // State register
  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt    = state;
    o_s_ready    = 1'b0;
    o_wr_en      = 1'b0;
    o_frame_done = 1'b0;
    o_overflow   = 1'b0;
    case (state)
      COLLECT: begin
        o_s_ready = 1'b1;
        if (close_beat) begin
          state_nxt  = HEADER;
          o_overflow = !i_s_last;
        end
      end
      HEADER: begin
        o_wr_en = i_wr_ready;
        if (i_wr_ready) begin
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        o_wr_en = i_wr_ready;
        if (i_wr_ready && pay_last) begin
`ifdef SAKEBI_FRAME_WRITER_CHECKSUM_EN
          state_nxt = TRAILER;
`else
          state_nxt    = COLLECT;
          o_frame_done = 1'b1;
`endif
        end
      end
`ifdef SAKEBI_FRAME_WRITER_CHECKSUM_EN
      TRAILER: begin
        o_wr_en = i_wr_ready;
        if (i_wr_ready) begin
          state_nxt    = COLLECT;
          o_frame_done = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  // Frame buffer: never reset; a frame is only emitted after being re-collected.
  always_ff @(posedge i_wr_clk) begin
    if (accept_beat) begin
      buffer[cnt[IW-1:0]] <= i_s_data;
    end
  end

  // Counters and output word register. wr_data_p0 always holds the word that
  // the current state presents, so a stall simply leaves it untouched.
  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      cnt        <= '0;
      idx        <= '0;
      wr_data_p0 <= '0;
`ifdef SAKEBI_FRAME_WRITER_CHECKSUM_EN
      chk_p0     <= '0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (accept_beat) begin
            cnt <= cnt + CW'(1);
`ifdef SAKEBI_FRAME_WRITER_CHECKSUM_EN
            chk_p0 <= chk_p0 ^ i_s_data;
`endif
          end
          if (close_beat) begin
            wr_data_p0 <= len_word(cnt + CW'(1));
          end
        end
        HEADER: begin
          if (i_wr_ready) begin
            idx        <= '0;
            wr_data_p0 <= buffer[0];
          end
        end
        PAYLOAD: begin
          if (i_wr_ready) begin
            if (pay_last) begin
`ifdef SAKEBI_FRAME_WRITER_CHECKSUM_EN
              wr_data_p0 <= chk_p0;
`else
              wr_data_p0 <= '0;
              cnt        <= '0;
              idx        <= '0;
`endif
            end else begin
              idx        <= idx + CW'(1);
              wr_data_p0 <= buffer[IW'(idx + CW'(1))];
            end
          end
        end
`ifdef SAKEBI_FRAME_WRITER_CHECKSUM_EN
        TRAILER: begin
          if (i_wr_ready) begin
            wr_data_p0 <= '0;
            cnt        <= '0;
            idx        <= '0;
            chk_p0     <= '0;
          end
        end
`endif
        default: begin
          cnt <= '0;
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sakebi_frame_writer.sv
module tb_sakebi_frame_writer;

  localparam int DW   = 8;
  localparam int MAXL = 16;
  localparam int NV   = 5;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          frame_done;
  logic          overflow;

  sakebi_frame_writer #(.DATA_WIDTH(DW), .MAX_LEN(MAXL)) dut (
    .i_wr_clk    (clk),
    .i_wr_rstn   (rst_n),
    .i_s_valid   (s_valid),
    .i_s_data    (s_data),
    .i_s_last    (s_last),
    .o_s_ready   (s_ready),
    .o_wr_en     (wr_en),
    .o_wr_data   (wr_data),
    .i_wr_ready  (wr_ready),
    .o_frame_done(frame_done),
    .o_overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              nb;
    logic [19:0][7:0] d;
    logic [19:0]      l;
    int              ne;
    logic [19:0][7:0] e;
    logic [19:0]      dn;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       dn;
  } exp_t;

  vec_t       tv [NV];
  exp_t       sb [$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cnt_m  = 0;
  logic [7:0] run_x  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected FIFO word; with the checksum build the frame's last payload word
  // is followed by a trailer holding the XOR of that frame's payload.
  task automatic push_w(input logic [7:0] d, input logic dn, input logic hdr);
    if (hdr) run_x = 8'h00;
    else     run_x = run_x ^ d;
`ifdef SAKEBI_FRAME_WRITER_CHECKSUM_EN
    if (dn) begin
      sb.push_back('{d: d, dn: 1'b0});
      sb.push_back('{d: run_x, dn: 1'b1});
    end else begin
      sb.push_back('{d: d, dn: 1'b0});
    end
`else
    sb.push_back('{d: d, dn: dn});
`endif
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int   w;
    logic got;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    w   = 0;
    got = 1'b0;
    while (!got && w < 200) begin
      @(negedge clk);
      if (s_ready) got = 1'b1;
      else         w++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout got ready=0 expected ready=1 data %0h", d);
    end else begin
      chk("overflow", 32'(overflow), 32'((cnt_m == MAXL - 1) && !l));
    end
    @(posedge clk);
    #1;
    if (l || cnt_m == MAXL - 1) cnt_m = 0;
    else                        cnt_m++;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 400) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor: every FIFO write must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got %0h expected none at %0t", wr_data, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_data", 32'(wr_data), 32'(mon_e.d));
        chk("frame_done", 32'(frame_done), 32'(mon_e.dn));
        chk("ready_during_write", 32'(s_ready), 32'd0);
      end
    end
  end

  initial begin
    // Vector table: input beats with last flags, expected FIFO words with done flags.
    for (int i = 0; i < NV; i++) begin
      tv[i].nb = 0; tv[i].d = '0; tv[i].l = '0;
      tv[i].ne = 0; tv[i].e = '0; tv[i].dn = '0;
    end
    tv[0].nb = 3; tv[0].d[0] = 8'h11; tv[0].d[1] = 8'h22; tv[0].d[2] = 8'h33; tv[0].l[2] = 1'b1;
    tv[0].ne = 4; tv[0].e[0] = 8'h03; tv[0].e[1] = 8'h11; tv[0].e[2] = 8'h22; tv[0].e[3] = 8'h33;
    tv[0].dn[3] = 1'b1;
    tv[1].nb = 1; tv[1].d[0] = 8'hA5; tv[1].l[0] = 1'b1;
    tv[1].ne = 2; tv[1].e[0] = 8'h01; tv[1].e[1] = 8'hA5; tv[1].dn[1] = 1'b1;
    tv[2].nb = 17;
    for (int j = 0; j < 17; j++) tv[2].d[j] = 8'(j);
    tv[2].l[16] = 1'b1;
    tv[2].ne = 19; tv[2].e[0] = 8'h10;
    for (int j = 0; j < 16; j++) tv[2].e[1+j] = 8'(j);
    tv[2].dn[16] = 1'b1; tv[2].e[17] = 8'h01; tv[2].e[18] = 8'h10; tv[2].dn[18] = 1'b1;
    tv[3].nb = 16;
    for (int j = 0; j < 16; j++) tv[3].d[j] = 8'(8'h80 + j);
    tv[3].l[15] = 1'b1;
    tv[3].ne = 17; tv[3].e[0] = 8'h10;
    for (int j = 0; j < 16; j++) tv[3].e[1+j] = 8'(8'h80 + j);
    tv[3].dn[16] = 1'b1;
    tv[4].nb = 2; tv[4].d[0] = 8'hC3; tv[4].d[1] = 8'h3C; tv[4].l[1] = 1'b1;
    tv[4].ne = 3; tv[4].e[0] = 8'h02; tv[4].e[1] = 8'hC3; tv[4].e[2] = 8'h3C; tv[4].dn[2] = 1'b1;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Back-to-back frames with valid held high between them.
    for (int v = 0; v < NV; v++) begin
      for (int j = 0; j < tv[v].ne; j++)
        push_w(tv[v].e[j], tv[v].dn[j], (j == 0) || tv[v].dn[(j == 0) ? 0 : j - 1]);
      for (int b = 0; b < tv[v].nb; b++)
        send_beat(tv[v].d[b], tv[v].l[b]);
    end
    s_valid = 1'b0; s_last = 1'b0;
    drain();

    // Stall during payload word 1 of a 4-beat frame.
    push_w(8'h04, 1'b0, 1'b1);
    push_w(8'h50, 1'b0, 1'b0);
    push_w(8'h51, 1'b0, 1'b0);
    push_w(8'h52, 1'b0, 1'b0);
    push_w(8'h53, 1'b1, 1'b0);
    send_beat(8'h50, 1'b0);
    send_beat(8'h51, 1'b0);
    send_beat(8'h52, 1'b0);
    send_beat(8'h53, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_wr_en", 32'(wr_en), 32'd0);
      chk("stall_wr_data", 32'(wr_data), 32'h51);
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    drain();

    // Reset after two beats of a frame discards it.
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    s_valid = 1'b0;
    rst_n = 1'b0;
    cnt_m = 0;
    #1;
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_wr_data", 32'(wr_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_writes", 32'(sb.size()), 32'd0);
    push_w(8'h01, 1'b0, 1'b1);
    push_w(8'h7E, 1'b1, 1'b0);
    send_beat(8'h7E, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sakebi_frame_writer.md
SAKEBI_FRAME_WRITER -- requirements
Module: sakebi_frame_writer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, byte width of stream and FIFO words; MAX_LEN, default 16, maximum payload beats per frame (2..2**DATA_WIDTH-1).
REQ-002 i_wr_clk  input  1  write-domain clock; all logic SHALL be clocked on its rising edge.
REQ-003 i_wr_rstn  input  1  reset; it SHALL be asynchronous and active-low.
REQ-004 i_s_valid  input  1  upstream beat valid.
REQ-005 i_s_data  input  DATA_WIDTH  upstream beat data.
REQ-006 i_s_last  input  1  marks final beat of a frame.
REQ-007 o_s_ready  output  1  block can accept a beat this cycle.
REQ-008 o_wr_en  output  1  write strobe to the async FIFO write port.
REQ-009 o_wr_data  output  DATA_WIDTH  word written to the FIFO.
REQ-010 i_wr_ready  input  1  FIFO not full.
REQ-011 o_frame_done  output  1  one-cycle pulse on the final FIFO write of a frame.
REQ-012 o_overflow  output  1  one-cycle pulse when a frame is force-split at MAX_LEN.

Function
REQ-013 FSM SHALL have states COLLECT, HEADER, PAYLOAD, and TRAILER (TRAILER only when the macro in REQ-027 is defined).
REQ-014 COLLECT: o_s_ready=1; each beat with i_s_valid=1 SHALL be stored at buffer[cnt], cnt incremented.
REQ-015 COLLECT->HEADER on the beat with i_s_last=1, or on the beat that makes cnt==MAX_LEN; that beat is stored, and o_s_ready is 0 from the next cycle.
REQ-016 A frame closed at MAX_LEN without i_s_last SHALL pulse o_overflow in the same cycle; the following beats start a new frame.
REQ-017 HEADER: o_wr_data SHALL equal the stored length L (1..MAX_LEN); PAYLOAD: o_wr_data=buffer[idx], idx 0..L-1.
REQ-018 o_wr_en SHALL be combinational: 1 in HEADER/PAYLOAD/TRAILER and i_wr_ready=1, else 0; a word advances only when o_wr_en=1.
REQ-019 HEADER->PAYLOAD after the header write; PAYLOAD->COLLECT (or TRAILER) after write of idx==L-1.
REQ-020 o_frame_done SHALL pulse with the last write of the frame (payload word L-1, or trailer when enabled).
REQ-021 Minimum latency: the last beat is accepted in cycle N, the header is written in N+1, and payload word k is written in N+2+k, provided i_wr_ready=1 throughout.
REQ-022 i_wr_ready low SHALL stall the current word with o_wr_data held stable; there is no word loss or duplication.
REQ-023 Next frame collection SHALL NOT start until the current frame's final write completes.
REQ-024 Counters SHALL be $clog2(MAX_LEN+1) bits wide and SHALL reset to 0 on return to COLLECT.

Reset
REQ-025 Asserting i_wr_rstn low SHALL, asynchronously, force COLLECT, cnt=idx=0, o_wr_data=0, o_frame_done=0, o_overflow=0, and the checksum register=0; o_s_ready reads 1 and o_wr_en reads 0 while reset is low and after release.
REQ-026 Reset mid-frame SHALL discard the partial frame; buffer contents are not reset and SHALL never be emitted without a new frame.

Configuration
REQ-027 Macro SAKEBI_FRAME_WRITER_CHECKSUM_EN: when defined, a TRAILER word equal to the XOR of all L payload words SHALL be written after the payload; the header still counts payload only (L).
REQ-028 Without SAKEBI_FRAME_WRITER_CHECKSUM_EN, the TRAILER state and the checksum register SHALL be absent, and a frame is exactly L+1 FIFO words.

Verification
REQ-029 Input beats 0x11,0x22,0x33 (last on 0x33), with i_wr_ready=1 -> FIFO writes 0x03,0x11,0x22,0x33; o_frame_done pulses with 0x33; with the macro defined, a fifth write of 0x00 follows.
REQ-030 Input of 17 beats 0x00..0x10 with no last, MAX_LEN=16 -> o_overflow pulses on beat 0x0F; writes are 0x10,0x00..0x0F; beat 0x10 begins the next frame.
REQ-031 Single beat 0xA5 with last -> writes 0x01,0xA5; with the macro defined, the trailer is 0xA5.
REQ-032 i_wr_ready=0 for 5 cycles during payload word 1 of a 4-beat frame -> o_wr_data holds buffer[1] and o_wr_en=0; after release, the remaining words appear in order with no duplicates.
REQ-033 i_wr_rstn pulsed low after 2 beats of a frame -> no FIFO writes occur, and a subsequent frame of 0x7E (last) yields exactly 0x01,0x7E.
REQ-034 Back-to-back frames with i_s_valid held high -> o_s_ready=0 from the cycle after last until the final write, and beats are not accepted in that window.
